// File: rtl/foc_loop_scheduler.sv
// Periodic start sequencer for the FOC current loop. It also queues host PID gain writes and
// drains them to the D/Q register files only between loop iterations.
module foc_loop_scheduler #(
  parameter int D_WIDTH   = 16,
  parameter int PERIOD_W  = 16,
  parameter int CFG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                foc_valid,
  input  logic                foc_ready,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                cfg_sel,
  input  logic [D_WIDTH-1:0]  cfg_addr,
  input  logic [D_WIDTH-1:0]  cfg_data,
  output logic                pid_d_wen,
  output logic                pid_q_wen,
  output logic [D_WIDTH-1:0]  pid_addr,
  output logic [D_WIDTH-1:0]  pid_data,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          overrun_cnt
);

  localparam int PTR_W   = $clog2(CFG_DEPTH);
  localparam int ENTRY_W = 2 * D_WIDTH + 1;

  typedef enum logic [1:0] {
    WAIT_TICK,
    LAUNCH,
    ACK,
    BUSY
  } state_t;

  state_t              state;
  logic [1:0]          ack_cnt;
  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] period_cur;
  logic [PERIOD_W-1:0] period_clamped;
  logic                tick;
  logic                tick_drop;
  logic                ack_timeout;
  logic                ov_evt;

  logic [ENTRY_W-1:0]  fifo_mem [CFG_DEPTH];
  logic [ENTRY_W-1:0]  head;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W:0]      fifo_count;
  logic                push;
  logic                pop;

  // The active period only changes while idle or at a wrap, so a host update never shortens a running period.
  assign period_clamped = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
  assign tick           = enable && (count == period_cur - PERIOD_W'(1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count      <= '0;
      period_cur <= PERIOD_W'(2);
    end else if (!enable) begin
      count      <= '0;
      period_cur <= period_clamped;
    end else if (tick) begin
      count      <= '0;
      period_cur <= period_clamped;
    end else begin
      count <= count + PERIOD_W'(1);
    end
  end

  assign tick_drop   = tick && !((state == WAIT_TICK) && foc_ready);
  assign ack_timeout = (state == ACK) && foc_ready && (ack_cnt == 2'd3);
  assign ov_evt      = tick_drop || ack_timeout;
  assign busy        = (state != WAIT_TICK);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= WAIT_TICK;
      ack_cnt     <= '0;
      foc_valid   <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      foc_valid <= 1'b0;
      overrun   <= ov_evt;
      if (ov_evt && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
      case (state)
        WAIT_TICK: begin
          if (tick && foc_ready) begin
            state     <= LAUNCH;
            foc_valid <= 1'b1;
          end
        end
        LAUNCH: begin
          state   <= ACK;
          ack_cnt <= '0;
        end
        ACK: begin
          if (!foc_ready) begin
            state <= BUSY;
          end else if (ack_cnt == 2'd3) begin
            state <= WAIT_TICK;
          end else begin
            ack_cnt <= ack_cnt + 2'd1;
          end
        end
        BUSY: begin
          if (foc_ready) begin
            state <= WAIT_TICK;
          end
        end
        default: state <= WAIT_TICK;
      endcase
    end
  end

  // Draining yields to a tick, so a PID write can never land in a cycle that starts an iteration.
  assign cfg_ready = (fifo_count != (PTR_W + 1)'(CFG_DEPTH));
  assign push      = cfg_valid && cfg_ready;
  assign pop       = (state == WAIT_TICK) && !tick && (fifo_count != '0);
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cfg_sel, cfg_addr, cfg_data};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pid_d_wen <= 1'b0;
      pid_q_wen <= 1'b0;
      pid_addr  <= '0;
      pid_data  <= '0;
    end else begin
      pid_d_wen <= pop && !head[ENTRY_W-1];
      pid_q_wen <= pop && head[ENTRY_W-1];
      if (pop) begin
        pid_addr <= head[2*D_WIDTH-1:D_WIDTH];
        pid_data <= head[D_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_foc_loop_scheduler.sv
// Directed bench for foc_loop_scheduler: a pipeline model answers the start handshake, and a
// scoreboard queue holds accepted config writes until the PID write ports deliver them.
module tb_foc_loop_scheduler;

  localparam int DW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = 16'd10;
  logic          foc_valid;
  logic          foc_ready = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          cfg_sel = 1'b0;
  logic [DW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic          pid_d_wen;
  logic          pid_q_wen;
  logic [DW-1:0] pid_addr;
  logic [DW-1:0] pid_data;
  logic          busy;
  logic          overrun;
  logic [7:0]    overrun_cnt;

  typedef struct packed {
    logic          sel;
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  nCompared = 0;
  int  nMismatched = 0;
  bit  pipe_stuck = 1'b0;
  bit  pipe_ignore = 1'b0;
  int  hold_len = 5;
  int  low_left = 0;
  int  ov_pulses = 0;
  int  wen_seen = 0;

  foc_loop_scheduler #(.D_WIDTH(DW), .PERIOD_W(PW), .CFG_DEPTH(4)) dut (
    .clk(clk), .rstb(rstb), .enable(enable), .period(period),
    .foc_valid(foc_valid), .foc_ready(foc_ready),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pid_d_wen(pid_d_wen), .pid_q_wen(pid_q_wen),
    .pid_addr(pid_addr), .pid_data(pid_data),
    .busy(busy), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic sel, input logic [DW-1:0] addr, input logic [DW-1:0] data);
    bit acc;
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_data  = data;
    acc = cfg_ready;
    @(posedge clk);
    if (acc) sb.push_back('{sel: sel, addr: addr, data: data});
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!foc_valid && cycles < budget);
    checkOutput(tag, foc_valid, 1);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, sb.size(), 0);
  endtask

  function automatic logic [31:0] satCnt(input int pulses);
    return (pulses > 255) ? 32'd255 : 32'(pulses);
  endfunction

  // Pipeline model: accepts a start by dropping ready, then stays low for hold_len cycles.
  always @(negedge clk) begin
    if (pipe_stuck) foc_ready = 1'b0;
    else if (low_left > 0) begin
      low_left--;
      if (low_left == 0) foc_ready = 1'b1;
    end else foc_ready = 1'b1;
    if (foc_valid && !pipe_ignore && !pipe_stuck) begin
      foc_ready = 1'b0;
      low_left  = hold_len;
    end
  end

  always @(negedge clk) begin
    if (!rstb) begin
      ov_pulses = 0;
    end else begin
      if (overrun) ov_pulses++;
      if (pid_d_wen || pid_q_wen) begin
        wen_seen++;
        checkOutput("wen_while_busy", busy, 0);
        if (sb.size() == 0) checkOutput("wen_unexpected", sb.size(), 1);
        else begin
          mon_e = sb.pop_front();
          checkOutput("wr_sel", {pid_q_wen, pid_d_wen}, mon_e.sel ? 32'd2 : 32'd1);
          checkOutput("wr_addr", pid_addr, mon_e.addr);
          checkOutput("wr_data", pid_data, mon_e.data);
        end
      end
      if (foc_valid) checkOutput("valid_wen_excl", {pid_d_wen, pid_q_wen}, 0);
    end
  end

  initial begin
    int cyc;
    int p0;
    int w0;
    int c0;

    repeat (3) @(negedge clk);
    checkOutput("rst_foc_valid", foc_valid, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_overrun_cnt", overrun_cnt, 0);
    checkOutput("rst_wen", {pid_d_wen, pid_q_wen}, 0);
    checkOutput("rst_pid_addr", pid_addr, 0);
    rstb = 1'b1;
    @(negedge clk);

    $display("[TB] steady loop, period 10");
    hold_len = 5;
    enable = 1'b1;
    waitValid("t1_first", 30, cyc);
    for (int i = 0; i < 3; i++) begin
      waitValid("t1_launch", 30, cyc);
      checkOutput("t1_interval", cyc, 10);
    end
    checkOutput("t1_overrun_cnt", overrun_cnt, 0);

    $display("[TB] long pipeline, every other tick dropped");
    @(negedge clk);
    hold_len = 15;
    waitValid("t2_launch", 30, cyc);
    for (int i = 0; i < 2; i++) begin
      p0 = ov_pulses;
      c0 = overrun_cnt;
      waitValid("t2_launch", 40, cyc);
      checkOutput("t2_interval", cyc, 20);
      checkOutput("t2_pulses", ov_pulses - p0, 1);
      checkOutput("t2_cnt_step", overrun_cnt, c0 + 1);
    end

    $display("[TB] start never accepted, ack timeout");
    @(negedge clk);
    hold_len = 5;
    pipe_ignore = 1'b1;
    waitValid("t_ack_launch", 40, cyc);
    p0 = ov_pulses;
    repeat (6) @(negedge clk);
    pipe_ignore = 1'b0;
    checkOutput("t_ack_pulse", ov_pulses - p0, 1);
    checkOutput("t_ack_idle", busy, 0);
    checkOutput("t_ack_cnt", overrun_cnt, satCnt(ov_pulses));

    $display("[TB] four config writes during a loop");
    waitValid("t3_launch", 30, cyc);
    w0 = wen_seen;
    for (int i = 1; i <= 4; i++) applyStimulus(1'(i % 2 == 0), DW'(i), DW'(16'hD000 + i));
    checkOutput("t3_cfg_full", cfg_ready, 0);
    checkOutput("t3_still_busy", busy, 1);
    waitDrain("t3_drained", 60);
    checkOutput("t3_wen_count", wen_seen - w0, 4);
    checkOutput("t3_cfg_ready", cfg_ready, 1);

    $display("[TB] config write on a tick cycle");
    waitValid("t4_launch", 40, cyc);
    w0 = wen_seen;
    repeat (9) @(negedge clk);
    applyStimulus(1'b0, 16'h00AA, 16'h1234);
    checkOutput("t4_valid_first", foc_valid, 1);
    checkOutput("t4_no_wen_yet", wen_seen - w0, 0);
    waitDrain("t4_drained", 40);
    checkOutput("t4_wen_count", wen_seen - w0, 1);

    $display("[TB] overrun saturation");
    period = 16'd2;
    pipe_stuck = 1'b1;
    repeat (800) @(negedge clk);
    checkOutput("t5_many_pulses", ov_pulses >= 300, 1);
    checkOutput("t5_saturated", overrun_cnt, 255);
    p0 = ov_pulses;
    repeat (10) @(negedge clk);
    checkOutput("t5_still_pulsing", ov_pulses - p0, 5);
    checkOutput("t5_held", overrun_cnt, satCnt(ov_pulses));

    $display("[TB] reset during busy with queued writes");
    pipe_stuck = 1'b0;
    period = 16'd10;
    hold_len = 15;
    waitValid("t6_launch", 60, cyc);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 16'h0055, 16'hBEEF);
    applyStimulus(1'b0, 16'h0066, 16'hCAFE);
    checkOutput("t6_busy_before", busy, 1);
    rstb = 1'b0;
    enable = 1'b0;
    #1;
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_foc_valid", foc_valid, 0);
    checkOutput("t6_cfg_ready", cfg_ready, 1);
    checkOutput("t6_overrun_cnt", overrun_cnt, 0);
    checkOutput("t6_pid_addr", pid_addr, 0);
    checkOutput("t6_pid_data", pid_data, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    w0 = wen_seen;
    repeat (20) @(negedge clk);
    checkOutput("t6_no_wen", wen_seen - w0, 0);
    checkOutput("t6_cfg_ready_after", cfg_ready, 1);
    checkOutput("t6_idle_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
